// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for a single-write-port register file: round-robin
// arbitration of NREQ requesters, registered write stage, per-register busy scoreboard.
module regfile_wb_sched #(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_ready,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [XLEN-1:0]      wr_data,
    input  logic [AW-1:0]        chkA_addr,
    output logic                 chkA_busy,
    input  logic [AW-1:0]        chkB_addr,
    output logic                 chkB_busy,
    output logic                 wb_orphan
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREG-1:0] busy;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;
    logic            issue_fire;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        xfer      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!xfer && req_valid[wrap_idx(rr_ptr, k)]) begin
                xfer                         = 1'b1;
                grant_idx                    = wrap_idx(rr_ptr, k);
                req_ready[wrap_idx(rr_ptr, k)] = 1'b1;
            end
        end
    end

    assign sel_addr = req_addr[grant_idx*AW +: AW];
    assign sel_data = req_data[grant_idx*XLEN +: XLEN];

    // A register whose final write is in the output stage this cycle is free again.
    assign issue_ready = (issue_rd == '0) | ~busy[issue_rd] | (wr_en & (wr_addr == issue_rd));
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

    assign chkA_busy = busy[chkA_addr] & ~(wr_en & (wr_addr == chkA_addr));
    assign chkB_busy = busy[chkB_addr] & ~(wr_en & (wr_addr == chkB_addr));

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wb_orphan <= 1'b0;
        end else begin
            wr_en     <= xfer && (sel_addr != '0);
            wb_orphan <= xfer && (sel_addr != '0) && !busy[sel_addr];
            if (xfer) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                rr_ptr  <= wrap_idx(grant_idx, 1);
            end
        end
    end

    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset to come up with nothing pending.
    // The set is written last so it wins over a same-edge clear; busy[0] is never set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_en) busy[wr_addr] <= 1'b0;
            if (issue_fire) busy[issue_rd] <= 1'b1;
        end
    end

endmodule
